// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC of the MIPS core. Advances sequentially
// under the imem handshake, applies beq/bne/j/jr redirects and holds a
// multi-cycle pipeline flush after every accepted redirect.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2               // legal range 1..7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [1:0]  flag,
  input  logic [31:0] jump_address,
  input  logic [31:0] branch_pc,
  input  logic [15:0] branch_imm,
  input  logic        stall,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        flush,
  output logic        redirect_taken,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Counter is loaded with FLUSH_CYCLES-1 so FLUSH lasts exactly FLUSH_CYCLES cycles.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        redirect_taken_q, redirect_taken_d;
  logic        addr_err_q, addr_err_d;

  logic [31:0] seq_base;
  logic [31:0] branch_off;
  logic [31:0] target;
  logic        target_misaligned;

  // Redirect target decode from the jump/branch unit's flag encoding.
  always_comb begin
    seq_base          = branch_pc + 32'd4;
    branch_off        = {{14{branch_imm[15]}}, branch_imm, 2'b00};
    target            = seq_base + branch_off;
    target_misaligned = 1'b0;
    case (flag)
      2'b00, 2'b01: target = seq_base + branch_off;
      2'b10:        target = {seq_base[31:28], jump_address[25:0], 2'b00};
      2'b11: begin
        // jr: low bits are forced to zero; a nonzero offset is reported.
        target            = {jump_address[31:2], 2'b00};
        target_misaligned = (jump_address[1:0] != 2'b00);
      end
      default: target = seq_base + branch_off;
    endcase
  end

  // Next-state, next-PC and one-shot pulse computation.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    cnt_d            = cnt_q;
    redirect_taken_d = 1'b0;
    addr_err_d       = 1'b0;
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (redirect_valid) begin
          // Redirect wins over stall/imem_ready; a pending fetch is dropped.
          pc_d             = target;
          state_d          = FLUSH;
          cnt_d            = FLUSH_LOAD;
          redirect_taken_d = 1'b1;
          addr_err_d       = (flag == 2'b11) && target_misaligned;
        end else if (imem_ready && !stall) begin
          pc_d = pc_q + 32'd4;
        end
      end
      FLUSH: begin
        // Any redirect seen here comes from a killed instruction.
        if (cnt_q == 3'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      pc_q             <= RESET_PC;
      cnt_q            <= 3'd0;
      redirect_taken_q <= 1'b0;
      addr_err_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      cnt_q            <= cnt_d;
      redirect_taken_q <= redirect_taken_d;
      addr_err_q       <= addr_err_d;
    end
  end

  assign pc             = pc_q;
  assign pc_valid       = (state_q == RUN);
  assign flush          = (state_q == FLUSH);
  assign redirect_taken = redirect_taken_q;
  assign addr_err       = addr_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized
// run against a cycle-level behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam int          FC       = 2;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [1:0]  flag;
  logic [31:0] jump_address;
  logic [31:0] branch_pc;
  logic [15:0] branch_imm;
  logic        stall;
  logic        imem_ready;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic        redirect_taken;
  logic        addr_err;

  pc_sequencer #(
    .RESET_PC    (RESET_PC),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_valid(redirect_valid),
    .flag          (flag),
    .jump_address  (jump_address),
    .branch_pc     (branch_pc),
    .branch_imm    (branch_imm),
    .stall         (stall),
    .imem_ready    (imem_ready),
    .pc            (pc),
    .pc_valid      (pc_valid),
    .flush         (flush),
    .redirect_taken(redirect_taken),
    .addr_err      (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: started flag, remaining flush cycles, pulses.
  logic [31:0] m_pc;
  logic        m_run;
  int          m_fl;
  logic        m_rt;
  logic        m_ae;

  logic [35:0] act_vec;
  assign act_vec = {pc, pc_valid, flush, redirect_taken, addr_err};

  function automatic logic [35:0] exp_vec();
    return {m_pc, (m_run && m_fl == 0), (m_fl != 0), m_rt, m_ae};
  endfunction

  function automatic logic [31:0] model_target(input logic [1:0] f, input logic [31:0] ja,
                                               input logic [31:0] bpc, input logic [15:0] imm);
    logic signed [31:0] words;
    words = 32'(signed'(imm));
    case (f)
      2'b00, 2'b01: return bpc + 32'd4 + 32'(words * 4);
      2'b10:        return ((bpc + 32'd4) & 32'hF000_0000) | ((ja & 32'h03FF_FFFF) << 2);
      default:      return ja & 32'hFFFF_FFFC;
    endcase
  endfunction

  task automatic model_reset();
    m_pc  = RESET_PC;
    m_run = 1'b0;
    m_fl  = 0;
    m_rt  = 1'b0;
    m_ae  = 1'b0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else if (!m_run) begin
      m_run = 1'b1;
      m_rt  = 1'b0;
      m_ae  = 1'b0;
    end else if (m_fl > 0) begin
      m_fl = m_fl - 1;
      m_rt = 1'b0;
      m_ae = 1'b0;
    end else if (redirect_valid) begin
      m_pc = model_target(flag, jump_address, branch_pc, branch_imm);
      m_fl = FC;
      m_rt = 1'b1;
      m_ae = (flag == 2'b11) && (jump_address % 4 != 0);
    end else begin
      if (imem_ready && !stall) m_pc = m_pc + 32'd4;
      m_rt = 1'b0;
      m_ae = 1'b0;
    end
  endtask

  // Advance one clock; the model samples the same inputs the DUT sees.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Issue one redirect from RUN and record what happens over the window.
  task automatic run_redirect(input logic [1:0] f, input logic [31:0] ja, input logic [31:0] bpc,
                              input logic [15:0] imm, input logic stl, input logic rdy,
                              input logic inject,
                              output logic [31:0] pc_first, output logic [31:0] pc_resume,
                              output logic pv_resume, output int n_fl, output int n_rt,
                              output int n_ae, output int n_coinc, output int n_pv_fl);
    redirect_valid = 1'b1;
    flag = f; jump_address = ja; branch_pc = bpc; branch_imm = imm;
    stall = stl; imem_ready = rdy;
    n_fl = 0; n_rt = 0; n_ae = 0; n_coinc = 0; n_pv_fl = 0;
    pc_first = '0; pc_resume = '0; pv_resume = 1'b0;
    tick();
    redirect_valid = inject;
    if (inject) begin
      flag = 2'b11; jump_address = 32'hDEAD_0000;
    end
    for (int i = 0; i < FC + 2; i++) begin
      if (i == 0) pc_first = pc;
      if (i == FC) begin
        pc_resume = pc;
        pv_resume = pc_valid;
      end
      if (flush) n_fl++;
      if (redirect_taken) n_rt++;
      if (addr_err) n_ae++;
      if (addr_err && redirect_taken) n_coinc++;
      if (flush && pc_valid) n_pv_fl++;
      redirect_valid = inject && (i + 1 < FC);
      tick();
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0; flag = '0; jump_address = '0; branch_pc = '0; branch_imm = '0;
    stall = 1'b0; imem_ready = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (act_vec !== exp_vec() || pc !== RESET_PC || pc_valid !== 1'b0 || flush !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", act_vec, exp_vec());
    end
    rst_n = 1'b1;
    imem_ready = 1'b1;
    n_checks++;
    if (pc_valid !== 1'b0 || pc !== 32'h0040_0000) begin
      n_fail++;
      $display("FAIL idle_cycle: got pc_valid=%b pc=%h expected pc_valid=0 pc=00400000", pc_valid, pc);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (pc !== 32'h0040_0000 + 32'(4 * i) || pc_valid !== 1'b1 || act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL seq_step%0d: got pc=%h valid=%b expected pc=%h valid=1", i, pc, pc_valid,
                 32'h0040_0000 + 32'(4 * i));
      end
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (pc !== 32'h0040_0008 || act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got pc=%h expected pc=00400008", i, pc);
      end
    end
    stall = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_branch();
    logic [31:0] p0, pr; logic pv; int nf, nr, na, nc, npv;
    run_redirect(2'b00, 32'h0, 32'h0040_0010, 16'hFFFC, 1'b0, 1'b1, 1'b0,
                 p0, pr, pv, nf, nr, na, nc, npv);
    n_checks++;
    if (p0 !== 32'h0040_0004 || pr !== 32'h0040_0004 || pv !== 1'b1 || nf != 2 || nr != 1 ||
        na != 0 || npv != 0) begin
      n_fail++;
      $display("FAIL branch: got first=%h resume=%h valid=%b flush=%0d rt=%0d ae=%0d expected 00400004 00400004 1 2 1 0",
               p0, pr, pv, nf, nr, na);
    end
    n_checks++;
    if (act_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL branch_model: got %h expected %h", act_vec, exp_vec());
    end
    $display("test_branch: target=%h flush_cycles=%0d", pr, nf);
  endtask

  task automatic test_jump();
    logic [31:0] p0, pr; logic pv; int nf, nr, na, nc, npv;
    run_redirect(2'b10, 32'h03FF_FFFF, 32'h1000_0000, 16'h0, 1'b0, 1'b0, 1'b0,
                 p0, pr, pv, nf, nr, na, nc, npv);
    n_checks++;
    if (pr !== 32'h1FFF_FFFC || pv !== 1'b1 || nr != 1 || na != 0) begin
      n_fail++;
      $display("FAIL jump: got pc=%h valid=%b rt=%0d ae=%0d expected 1ffffffc 1 1 0", pr, pv, nr, na);
    end
    $display("test_jump: target=%h", pr);
  endtask

  task automatic test_jr_misaligned();
    logic [31:0] p0, pr; logic pv; int nf, nr, na, nc, npv;
    run_redirect(2'b11, 32'h0000_1237, 32'h0, 16'h0, 1'b0, 1'b1, 1'b0,
                 p0, pr, pv, nf, nr, na, nc, npv);
    n_checks++;
    if (pr !== 32'h0000_1234 || na != 1 || nc != 1 || nr != 1) begin
      n_fail++;
      $display("FAIL jr_misaligned: got pc=%h ae=%0d coinc=%0d rt=%0d expected 00001234 1 1 1", pr, na, nc, nr);
    end
    n_checks++;
    if (act_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL jr_model: got %h expected %h", act_vec, exp_vec());
    end
    $display("test_jr_misaligned: target=%h addr_err_pulses=%0d", pr, na);
  endtask

  task automatic test_back_to_back();
    logic [31:0] p0, pr; logic pv; int nf, nr, na, nc, npv;
    // Redirect with stall=1, imem_ready=0, and a second redirect held during FLUSH.
    run_redirect(2'b01, 32'h0, 32'h0000_1000, 16'h0010, 1'b1, 1'b0, 1'b1,
                 p0, pr, pv, nf, nr, na, nc, npv);
    stall = 1'b0;
    n_checks++;
    if (pr !== 32'h0000_1044 || pv !== 1'b1 || nf != FC || nr != 1 || npv != 0) begin
      n_fail++;
      $display("FAIL back_to_back: got pc=%h valid=%b flush=%0d rt=%0d expected 00001044 1 %0d 1", pr, pv, nf, nr, FC);
    end
    $display("test_back_to_back: target=%h redirects=%0d", pr, nr);
  endtask

  task automatic test_wrap();
    logic [31:0] p0, pr; logic pv; int nf, nr, na, nc, npv;
    run_redirect(2'b11, 32'hFFFF_FFFC, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0,
                 p0, pr, pv, nf, nr, na, nc, npv);
    n_checks++;
    if (pr !== 32'hFFFF_FFFC || na != 0) begin
      n_fail++;
      $display("FAIL wrap_target: got pc=%h ae=%0d expected fffffffc 0", pr, na);
    end
    imem_ready = 1'b1;
    tick();
    n_checks++;
    if (pc !== 32'h0 || act_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL wrap: got pc=%h expected 00000000", pc);
    end
    $display("test_wrap: pc=%h", pc);
  endtask

  task automatic test_async_reset();
    imem_ready = 1'b1;
    redirect_valid = 1'b1; flag = 2'b00; branch_pc = 32'h0000_2000; branch_imm = 16'h0;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (flush !== 1'b1 || pc !== 32'h0000_2004) begin
      n_fail++;
      $display("FAIL pre_reset_flush: got flush=%b pc=%h expected 1 00002004", flush, pc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (flush !== 1'b0 || pc !== RESET_PC || pc_valid !== 1'b0 || redirect_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got flush=%b pc=%h valid=%b rt=%b expected 0 %h 0 0",
               flush, pc, pc_valid, redirect_taken, RESET_PC);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (act_vec !== exp_vec() || pc !== RESET_PC || pc_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset: got %h expected %h", act_vec, exp_vec());
    end
    $display("test_async_reset: pc=%h", pc);
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      redirect_valid = ($urandom_range(0, 3) == 0);
      flag           = 2'($urandom_range(0, 3));
      jump_address   = $urandom;
      branch_pc      = $urandom;
      branch_imm     = 16'($urandom);
      stall          = ($urandom_range(0, 3) == 0);
      imem_ready     = ($urandom_range(0, 3) != 0);
      tick();
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        errs++;
        if (errs < 10)
          $display("FAIL random_cycle%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    redirect_valid = 1'b0;
    $display("test_random: 400 cycles, %0d differences", errs);
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump();
    test_jr_misaligned();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the MIPS core. It consumes the `flag`/`jump_address` redirect encoding that the jump/branch unit produces and owns the architectural fetch PC. It computes the next PC: sequential, beq/bne target, j target, or jr register target. It handshakes fetch requests with instruction memory and drives a multi-cycle pipeline flush after every taken redirect.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `FLUSH_CYCLES`, 2, number of cycles `flush` stays high per redirect; legal range 1..7.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `redirect_valid`  in  1  control asserts this when `flag` carries a taken redirect. `flag` is don't-care when this is low.
- `flag`  in  2  redirect kind: 00 beq taken, 01 bne taken, 10 j, 11 jr.
- `jump_address`  in  32  for 10: low 26 bits are the word index. For 11: full byte target (register value).
- `branch_pc`  in  32  byte PC of the redirecting instruction.
- `branch_imm`  in  16  signed word offset for beq/bne.
- `stall`  in  1  freezes sequential PC advance.
- `imem_ready`  in  1  instruction memory accepts the current `pc`.
- `pc`  out  32  current fetch address (registered).
- `pc_valid`  out  1  fetch request valid.
- `flush`  out  1  kill all younger in-flight instructions.
- `redirect_taken`  out  1  one-cycle pulse per accepted redirect.
- `addr_err`  out  1  one-cycle pulse when a jr target is not word-aligned.

## Operation
- States: IDLE, RUN, FLUSH. A 3-bit flush counter is used in FLUSH.
- Reset (async, any state, any cycle):
  - state = IDLE.
  - `pc` = RESET_PC.
  - `pc_valid`, `flush`, `redirect_taken`, `addr_err` = 0.
  - Flush counter = 0.
  - Any redirect in progress is discarded.
- IDLE: unconditionally moves to RUN on the first rising edge after `rst_n` deasserts. `pc` is unchanged.
- RUN:
  - `pc_valid` = 1.
  - If `redirect_valid`=1: load `pc` with the target, enter FLUSH, load the counter with FLUSH_CYCLES-1. Redirect has priority over `stall` and `imem_ready`; an unaccepted fetch is abandoned.
  - Else if `imem_ready`=1 and `stall`=0: `pc` <= `pc`+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0).
  - Else: hold `pc`.
- Target computation (all arithmetic mod 2^32):
  - 00/01: `branch_pc` + 4 + ({{14{imm[15]}}, imm, 2'b00}).
  - 10: {(`branch_pc`+4)[31:28], `jump_address`[25:0], 2'b00}.
  - 11: {`jump_address`[31:2], 2'b00}. If `jump_address`[1:0] != 0, `addr_err` pulses in the first FLUSH cycle.
- FLUSH:
  - `flush` = 1, `pc_valid` = 0, `pc` holds the target.
  - `redirect_valid` is ignored, because it comes from a killed instruction. `stall` and `imem_ready` are also ignored.
  - If counter = 0, go to RUN; else decrement the counter.
- `redirect_taken` and `addr_err` are registered outputs. They are high only in the first FLUSH cycle.

## Timing
- Fetch latency: `pc` presents a new address one cycle after the advancing edge. Throughput is one fetch per cycle when `imem_ready`=1 and `stall`=0.
- Redirect latency:
  - At edge E, with RUN and `redirect_valid`=1, the redirect is sampled.
  - During cycles E+1..E+FLUSH_CYCLES: `flush`=1, `pc`=target, `pc_valid`=0.
  - At cycle E+FLUSH_CYCLES+1: `pc_valid`=1 with `pc`=target.
- Back-to-back redirects: a second redirect is only accepted in RUN. Minimum spacing is FLUSH_CYCLES+1 edges.
- Reset mid-FLUSH: `flush` drops immediately (asynchronously) and `pc` returns to RESET_PC.
- Fetch handshake: `pc` is stable while `pc_valid`=1 and `imem_ready`=0.

## Test plan
- Reset/IDLE:
  - Stimulus: RESET_PC=32'h0040_0000, deassert `rst_n`.
  - Required: one cycle with `pc_valid`=0, then `pc` steps 0x00400000, 0x00400004, 0x00400008 with `imem_ready`=1.
  - Then set `stall`=1 for 3 cycles: `pc` holds 0x00400008.
- Branch taken:
  - Stimulus: `flag`=00, `branch_pc`=0x00400010, `branch_imm`=16'hFFFC.
  - Required: target 0x00400004. `flush` high exactly 2 cycles, `redirect_taken` one pulse, then fetch resumes at 0x00400004.
- Jump:
  - Stimulus: `flag`=10, `branch_pc`=0x1000_0000, `jump_address`=32'h03FF_FFFF.
  - Required: `pc`=0x1FFF_FFFC after the flush.
- jr misaligned:
  - Stimulus: `flag`=11, `jump_address`=0x0000_1237.
  - Required: `pc`=0x0000_1234 and `addr_err` one pulse coincident with `redirect_taken`.
- Redirect during FLUSH, stall, and imem_ready=0:
  - A second `redirect_valid` asserted during FLUSH is ignored.
  - A redirect asserted with `stall`=1 and `imem_ready`=0 is still taken.
- Wrap and async reset:
  - `pc`=0xFFFF_FFFC advances to 0.
  - Asserting `rst_n`=0 mid-FLUSH drops `flush` immediately and `pc`=RESET_PC.
